// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, baud_set codes, receiver FSM states
// and the framing bit levels used by both the transmitter and the receiver.
package uart_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int OVERSAMPLE  = 16;
    localparam int DIV_W       = 9;

    // Divider terminal counts; one oversample tick every DIV+1 clocks.
    localparam logic [DIV_W-1:0] DIV_9600   = 9'd324;
    localparam logic [DIV_W-1:0] DIV_19200  = 9'd162;
    localparam logic [DIV_W-1:0] DIV_38400  = 9'd80;
    localparam logic [DIV_W-1:0] DIV_57600  = 9'd53;
    localparam logic [DIV_W-1:0] DIV_115200 = 9'd26;

    localparam int BIT_CLK_9600   = OVERSAMPLE * 325;
    localparam int BIT_CLK_19200  = OVERSAMPLE * 163;
    localparam int BIT_CLK_38400  = OVERSAMPLE * 81;
    localparam int BIT_CLK_57600  = OVERSAMPLE * 54;
    localparam int BIT_CLK_115200 = OVERSAMPLE * 27;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Unused codes 5-7 fall back to 9600.
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] code);
        case (code)
            BAUD_19200:  return DIV_19200;
            BAUD_38400:  return DIV_38400;
            BAUD_57600:  return DIV_57600;
            BAUD_115200: return DIV_115200;
            default:     return DIV_9600;
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator. The divisor is captured from baud_set_i on
// clear_i so a baud change during a frame has no effect until the next start.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic [2:0] baud_set_i,
    output logic       tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             tick_q;

    // Tick is registered, so it appears the cycle after the counter hits div_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= DIV_9600;
            tick_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            div_q  <= baud_div(baud_set_i);
            tick_q <= 1'b0;
        end else if (cnt_q == div_q) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. Define UART_RX_MAJORITY_EN for
// 2-of-3 majority sampling around mid-bit; otherwise a single mid-bit sample.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_set,
    input  logic       uart_rxd,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    logic       sync1_q, sync2_q, sync3_q;
    rx_state_e  state_q;
    logic [3:0] sCnt_q;
    logic [3:0] bitIdx_q;
    logic [7:0] shift_q;
    logic [7:0] dataByte_q;
    logic       rxDone_q, frameErr_q, rxBusy_q;
    logic       sampMid_q;
    logic       tick, startEdge, startDet, decide, bitVal;

    // sync3_q only exists to give the previous synced value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign startEdge = sync3_q & ~sync2_q;
    assign startDet  = (state_q == IDLE) && startEdge;
    assign decide    = tick && (sCnt_q == 4'd8);

    uart_baud_tick u_tick (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (startDet),
        .baud_set_i (baud_set),
        .tick_o     (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic sampEarly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sampEarly_q <= 1'b1;
            sampMid_q   <= 1'b1;
        end else if (tick) begin
            if (sCnt_q == 4'd6) sampEarly_q <= sync2_q;
            if (sCnt_q == 4'd7) sampMid_q   <= sync2_q;
        end
    end

    assign bitVal = majority3(sampEarly_q, sampMid_q, sync2_q);
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            sampMid_q <= 1'b1;
        end else if (tick && (sCnt_q == 4'd7)) begin
            sampMid_q <= sync2_q;
        end
    end

    assign bitVal = sampMid_q;
`endif

    // Frame FSM; every bit is resolved on the tick that moves sCnt_q to 9.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sCnt_q     <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            dataByte_q <= '0;
            rxDone_q   <= 1'b0;
            frameErr_q <= 1'b0;
            rxBusy_q   <= 1'b0;
        end else begin
            rxDone_q   <= 1'b0;
            frameErr_q <= 1'b0;
            if (tick) sCnt_q <= sCnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (startEdge) begin
                        state_q  <= START;
                        sCnt_q   <= '0;
                        bitIdx_q <= '0;
                        rxBusy_q <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        if (bitVal == START_BIT) begin
                            state_q  <= DATA;
                            bitIdx_q <= 4'd1;
                        end else begin
                            state_q  <= IDLE;
                            rxBusy_q <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_q  <= {bitVal, shift_q[7:1]};
                        bitIdx_q <= bitIdx_q + 1'b1;
                        if (bitIdx_q == 4'd8) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (decide) begin
                        state_q  <= IDLE;
                        rxBusy_q <= 1'b0;
                        bitIdx_q <= '0;
                        if (bitVal == STOP_BIT) begin
                            dataByte_q <= shift_q;
                            rxDone_q   <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_byte = dataByte_q;
    assign rx_done   = rxDone_q;
    assign frame_err = frameErr_q;
    assign rx_busy   = rxBusy_q;

endmodule
